// File: rtl/morph_pkg.sv
// Shared types and constants for the binary morphology window filter.
package morph_pkg;

  // Frame-level operation selected by the mode input (5-7 decode as bypass).
  typedef enum logic [2:0] {
    BYPASS = 3'd0,
    ERODE  = 3'd1,
    DILATE = 3'd2,
    OPEN   = 3'd3,
    CLOSE  = 3'd4
  } morph_mode_e;

  // Per-stage window reduction.
  typedef enum logic [1:0] {
    PASS   = 2'd0,
    AND_OP = 2'd1,
    OR_OP  = 2'd2
  } stage_op_e;

  // Frame-sync control states.
  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } ctrl_state_e;

  localparam int STAGE_LAT = 2;
  localparam int TOTAL_LAT = 5;

endpackage

// File: rtl/morph_stage.sv
// One morphology stage: KSIZE-1 one-bit line buffers, a KSIZE x KSIZE causal
// window and an AND/OR/pass reduction. Two register levels, so latency is 2
// clocks whatever the op. The window result is tagged with the input
// coordinates of the pixel that completed it.
module morph_stage
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int KSIZE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  stage_op_e          op,
  input  logic               in_b,
  input  logic               in_v,
  input  logic [X_WIDTH-1:0] in_x,
  input  logic [Y_WIDTH-1:0] in_y,
  output logic               out_b,
  output logic               out_v,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y
);

  localparam int NB = KSIZE - 1;
  localparam logic [X_WIDTH:0] IMG_W_EXT = (X_WIDTH + 1)'(IMG_WIDTH);

  // Line buffers hold no reset: rows above y = KSIZE-1 are masked by the border rule.
  logic                     lb [NB][IMG_WIDTH];
  logic [NB-1:0]            lb_rd;
  logic [KSIZE-1:0]         col_new;
  logic                     x_ok;
  // Window: row r occupies bits [r*KSIZE +: KSIZE]; row KSIZE-1 is the
  // current line and bit KSIZE-1 of each row is the newest column.
  logic [KSIZE*KSIZE-1:0]   win_q;
  logic                     v1_q;
  logic [X_WIDTH-1:0]       x1_q;
  logic [Y_WIDTH-1:0]       y1_q;
  logic                     border;
  logic                     result;

  // Handshake: qualifier only, no back-pressure. A pixel transfers on every
  // clock where its valid (in_v / out_v) is 1; there is no ready signal.

  assign x_ok = ({1'b0, in_x} < IMG_W_EXT);

  // Build the incoming window column: current pixel plus the rows above it.
  always_comb begin
    lb_rd   = '0;
    col_new = '0;
    if (x_ok) begin
      for (int j = 0; j < NB; j++) lb_rd[j] = lb[j][in_x];
    end
    col_new[KSIZE-1] = in_b;
    for (int j = 0; j < NB; j++) col_new[KSIZE-2-j] = lb_rd[j];
  end

  // Line buffer cascade; out-of-range columns never write.
  always_ff @(posedge clk) begin
    if (in_v && x_ok) begin
      lb[0][in_x] <= in_b;
      for (int j = 1; j < NB; j++) lb[j][in_x] <= lb[j-1][in_x];
    end
  end

  // Window shift and coordinate capture, frozen while in_v is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      v1_q  <= 1'b0;
      x1_q  <= '0;
      y1_q  <= '0;
    end else begin
      v1_q <= in_v;
      if (in_v) begin
        x1_q <= in_x;
        y1_q <= in_y;
        for (int r = 0; r < KSIZE; r++)
          win_q[r*KSIZE +: KSIZE] <= {col_new[r], win_q[r*KSIZE+1 +: KSIZE-1]};
      end
    end
  end

  // Window reduction; the border masks partial windows at line/frame start.
  always_comb begin
    border = (x1_q < X_WIDTH'(KSIZE - 1)) || (y1_q < Y_WIDTH'(KSIZE - 1));
    result = 1'b0;
    case (op)
      PASS:    result = win_q[KSIZE*KSIZE-1];
      AND_OP:  result = !border && (&win_q);
      OR_OP:   result = !border && (|win_q);
      default: result = 1'b0;
    endcase
  end

  // Output register; coordinates hold their last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_b <= 1'b0;
      out_v <= 1'b0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      out_v <= v1_q;
      out_b <= v1_q & result;
      if (v1_q) begin
        out_x <= x1_q;
        out_y <= y1_q;
      end
    end
  end

endmodule

// File: rtl/morph_window_filter.sv
// Binary morphology filter for the VGA pixel path: binarise, then two
// morph_stage instances in series (erode/dilate/open/close/bypass), mode
// latched at each start of frame. Fixed 5-clock latency.
// Build option: MORPH_THRESH_EN selects threshold binarisation on the
// RGB component sum instead of the red MSB.
module morph_window_filter
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int KSIZE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        i_data,
  input  logic [X_WIDTH-1:0] x_coor,
  input  logic [Y_WIDTH-1:0] y_coor,
  input  logic               DE,
  input  logic [2:0]         mode,
  input  logic [3:0]         thresh,
  output logic [11:0]        o_data,
  output logic               o_valid,
  output logic [X_WIDTH-1:0] o_x,
  output logic [Y_WIDTH-1:0] o_y,
  output ctrl_state_e        dbg_state
);

  ctrl_state_e        state_q, state_d;
  logic [2:0]         mode_q;
  logic               sof;
  logic               run_in;
  logic               bin_d;
  logic               b0_q, v0_q;
  logic [X_WIDTH-1:0] x0_q, x_mid;
  logic [Y_WIDTH-1:0] y0_q, y_mid;
  logic               b_mid, v_mid;
  logic               b_out, v_out;
  stage_op_e          op1, op2;

  assign sof       = DE && (x_coor == '0) && (y_coor == '0);
  // The start-of-frame pixel itself belongs to the new frame.
  assign run_in    = (state_q == RUN) || sof;
  assign dbg_state = state_q;

`ifdef MORPH_THRESH_EN
  logic [5:0] px_sum;
  logic [5:0] thr_x3;
  assign px_sum = 6'(i_data[11:8]) + 6'(i_data[7:4]) + 6'(i_data[3:0]);
  assign thr_x3 = 6'(thresh) * 6'd3;
  assign bin_d  = (px_sum >= thr_x3);
`else
  logic unused_inputs;
  assign unused_inputs = ^{thresh, i_data[10:0]};
  assign bin_d         = i_data[11];
`endif

  // Control state register and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SOF;
      mode_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      if (sof) mode_q <= mode;
    end
  end

  // Next state: leave WAIT_SOF on the first (0,0) pixel, then stay in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: if (sof) state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // Binarise stage, with coordinates and qualifier registered alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      b0_q <= 1'b0;
      v0_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
    end else begin
      b0_q <= bin_d;
      v0_q <= DE && run_in;
      x0_q <= x_coor;
      y0_q <= y_coor;
    end
  end

  // Map the latched mode onto the two stage operations.
  always_comb begin
    op1 = PASS;
    op2 = PASS;
    case (morph_mode_e'(mode_q))
      ERODE:   begin op1 = AND_OP; op2 = PASS;   end
      DILATE:  begin op1 = OR_OP;  op2 = PASS;   end
      OPEN:    begin op1 = AND_OP; op2 = OR_OP;  end
      CLOSE:   begin op1 = OR_OP;  op2 = AND_OP; end
      default: begin op1 = PASS;   op2 = PASS;   end
    endcase
  end

  morph_stage #(
    .IMG_WIDTH(IMG_WIDTH), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .KSIZE(KSIZE)
  ) u_stage1 (
    .clk(clk), .reset(reset), .op(op1),
    .in_b(b0_q), .in_v(v0_q), .in_x(x0_q), .in_y(y0_q),
    .out_b(b_mid), .out_v(v_mid), .out_x(x_mid), .out_y(y_mid)
  );

  morph_stage #(
    .IMG_WIDTH(IMG_WIDTH), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .KSIZE(KSIZE)
  ) u_stage2 (
    .clk(clk), .reset(reset), .op(op2),
    .in_b(b_mid), .in_v(v_mid), .in_x(x_mid), .in_y(y_mid),
    .out_b(b_out), .out_v(v_out), .out_x(o_x), .out_y(o_y)
  );

  assign o_valid = v_out;
  assign o_data  = {12{v_out & b_out}};

endmodule

// File: tb/tb_morph_window_filter.sv
// Bench for morph_window_filter: KSIZE=3 and KSIZE=5 instances share the
// stimulus; a frame-level reference model fills expected queues and
// per-instance monitors compare every output cycle.
module tb_morph_window_filter;
  import morph_pkg::*;

  localparam int MAXW = 256;
  localparam int MAXH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] i_data = '0;
  logic [9:0]  x_coor = '0, y_coor = '0;
  logic        DE = 1'b0;
  logic [2:0]  mode = '0;
  logic [3:0]  thresh = 4'd4;

  logic [11:0] o_data3, o_data5;
  logic        o_valid3, o_valid5;
  logic [9:0]  o_x3, o_y3, o_x5, o_y5;
  ctrl_state_e st3, st5;

  morph_window_filter #(.IMG_WIDTH(640), .X_WIDTH(10), .Y_WIDTH(10), .KSIZE(3)) dut3 (
    .clk(clk), .reset(reset), .i_data(i_data), .x_coor(x_coor), .y_coor(y_coor),
    .DE(DE), .mode(mode), .thresh(thresh), .o_data(o_data3), .o_valid(o_valid3),
    .o_x(o_x3), .o_y(o_y3), .dbg_state(st3));

  morph_window_filter #(.IMG_WIDTH(640), .X_WIDTH(10), .Y_WIDTH(10), .KSIZE(5)) dut5 (
    .clk(clk), .reset(reset), .i_data(i_data), .x_coor(x_coor), .y_coor(y_coor),
    .DE(DE), .mode(mode), .thresh(thresh), .o_data(o_data5), .o_valid(o_valid5),
    .o_x(o_x5), .o_y(o_y5), .dbg_state(st5));

  // ---------------- scoreboard state ----------------
  logic [31:0] exp3_q[$];
  logic [31:0] exp5_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic exp_v_cur = 1'b0;
  logic [4:0] hist = '0;

  logic [11:0] rgb [MAXH][MAXW];
  bit pix [MAXH][MAXW];
  bit s1  [MAXH][MAXW];
  bit e3  [MAXH][MAXW];
  bit e5  [MAXH][MAXW];

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic bit binar(input logic [11:0] p, input logic [3:0] t);
`ifdef MORPH_THRESH_EN
    return (int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0])) >= 3 * int'(t);
`else
    return p[11];
`endif
  endfunction

  // op: 0 pass, 1 and, 2 or
  function automatic bit stage_px(input int op, input int k, input bit from_s1,
                                  input int x, input int y);
    bit acc;
    bit v;
    if (op == 0) return from_s1 ? s1[y][x] : pix[y][x];
    if (x < k - 1 || y < k - 1) return 1'b0;
    acc = (op == 1);
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++) begin
        v = from_s1 ? s1[y-i][x-j] : pix[y-i][x-j];
        acc = (op == 1) ? (acc & v) : (acc | v);
      end
    return acc;
  endfunction

  task automatic build_expect(input int k, input int m, input int w, input int h);
    int op1, op2;
    bit r;
    case (m)
      1: begin op1 = 1; op2 = 0; end
      2: begin op1 = 2; op2 = 0; end
      3: begin op1 = 1; op2 = 2; end
      4: begin op1 = 2; op2 = 1; end
      default: begin op1 = 0; op2 = 0; end
    endcase
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) s1[y][x] = stage_px(op1, k, 1'b0, x, y);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        r = stage_px(op2, k, 1'b1, x, y);
        if (k == 3) e3[y][x] = r; else e5[y][x] = r;
      end
  endtask

  // ---------------- latency reference and monitors ----------------
  always @(posedge clk) begin
    if (reset) hist <= '0;
    else       hist <= {hist[3:0], exp_v_cur};
  end

  int lx3 = 0, ly3 = 0, lx5 = 0, ly5 = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      lx3 = 0; ly3 = 0;
    end else begin
      check("k3_valid_lag", int'(o_valid3), int'(hist[4]));
      if (o_valid3) begin
        if (exp3_q.size() == 0) check("k3_unexpected_valid", 1, 0);
        else begin
          e = exp3_q.pop_front();
          check("k3_data", int'(o_data3), int'(e[31:20]));
          check("k3_x", int'(o_x3), int'(e[19:10]));
          check("k3_y", int'(o_y3), int'(e[9:0]));
          lx3 = int'(e[19:10]); ly3 = int'(e[9:0]);
        end
      end else begin
        check("k3_idle_data", int'(o_data3), 0);
        check("k3_hold_x", int'(o_x3), lx3);
        check("k3_hold_y", int'(o_y3), ly3);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      lx5 = 0; ly5 = 0;
    end else begin
      check("k5_valid_lag", int'(o_valid5), int'(hist[4]));
      if (o_valid5) begin
        if (exp5_q.size() == 0) check("k5_unexpected_valid", 1, 0);
        else begin
          e = exp5_q.pop_front();
          check("k5_data", int'(o_data5), int'(e[31:20]));
          check("k5_x", int'(o_x5), int'(e[19:10]));
          check("k5_y", int'(o_y5), int'(e[9:0]));
          lx5 = int'(e[19:10]); ly5 = int'(e[9:0]);
        end
      end else begin
        check("k5_idle_data", int'(o_data5), 0);
        check("k5_hold_x", int'(o_x5), lx5);
        check("k5_hold_y", int'(o_y5), ly5);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals();
    check("rst_valid3", int'(o_valid3), 0);
    check("rst_data3", int'(o_data3), 0);
    check("rst_x3", int'(o_x3), 0);
    check("rst_y3", int'(o_y3), 0);
    check("rst_state3", int'(st3), int'(WAIT_SOF));
    check("rst_valid5", int'(o_valid5), 0);
    check("rst_data5", int'(o_data5), 0);
    check("rst_x5", int'(o_x5), 0);
    check("rst_y5", int'(o_y5), 0);
    check("rst_state5", int'(st5), int'(WAIT_SOF));
  endtask

  // Advance one clock; a reset raised last cycle is checked and released here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      check_reset_vals();
      exp3_q.delete();
      exp5_q.delete();
      reset = 1'b0;
    end
  endtask

  task automatic idle();
    tick();
    DE = 1'b0;
    i_data = 12'($urandom);
    x_coor = 10'($urandom);
    y_coor = 10'($urandom);
    exp_v_cur = 1'b0;
  endtask

  task automatic drive_frame(input int w, input int h, input int m1, input int m2,
                             input int chg_row, input int rst_x, input int rst_y,
                             input int hbl);
    bit dropped;
    dropped = 1'b0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) pix[y][x] = binar(rgb[y][x], thresh);
    build_expect(3, m1, w, h);
    build_expect(5, m1, w, h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        tick();
        i_data = rgb[y][x];
        x_coor = 10'(x);
        y_coor = 10'(y);
        DE = 1'b1;
        mode = (chg_row >= 0 && y >= chg_row) ? 3'(m2) : 3'(m1);
        if (x == rst_x && y == rst_y) begin
          reset = 1'b1;
          dropped = 1'b1;
          exp_v_cur = 1'b0;
        end else if (dropped) begin
          exp_v_cur = 1'b0;
        end else begin
          exp_v_cur = 1'b1;
          exp3_q.push_back({(e3[y][x] ? 12'hFFF : 12'h000), 10'(x), 10'(y)});
          exp5_q.push_back({(e5[y][x] ? 12'hFFF : 12'h000), 10'(x), 10'(y)});
        end
      end
      for (int i = 0; i < hbl; i++) idle();
    end
    repeat (8) idle();
  endtask

  task automatic fill_const(input int w, input int h, input logic [11:0] v);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) rgb[y][x] = v;
  endtask

  task automatic fill_rand(input int w, input int h, input int dens);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        rgb[y][x] = ($urandom_range(0, 99) < dens) ? 12'($urandom_range(12'h800, 12'hFFF))
                                                   : 12'($urandom_range(0, 12'h7FF));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // Erode a uniform object field.
    thresh = 4'd4;
    fill_const(16, 8, 12'hF00);
    drive_frame(16, 8, 1, 1, -1, -1, -1, 3);

    // Single white pixel: open removes it, dilate grows it.
    fill_const(104, 54, 12'h000);
    rgb[50][100] = 12'hFFF;
    drive_frame(104, 54, 3, 3, -1, -1, -1, 2);
    drive_frame(104, 54, 2, 2, -1, -1, -1, 2);

    // White field with one hole: close fills it.
    fill_const(204, 104, 12'hFFF);
    rgb[100][200] = 12'h000;
    drive_frame(204, 104, 4, 4, -1, -1, -1, 1);

    // Mode written mid-frame takes effect only at the next frame.
    fill_rand(20, 10, 60);
    drive_frame(20, 10, 1, 2, 4, -1, -1, 3);
    fill_rand(20, 10, 60);
    drive_frame(20, 10, 2, 2, -1, -1, -1, 3);

    // Reset mid-frame, then a clean frame.
    fill_rand(24, 12, 50);
    drive_frame(24, 12, 3, 3, -1, 10, 6, 2);
    fill_rand(24, 12, 50);
    drive_frame(24, 12, 4, 4, -1, -1, -1, 2);

    // Randomised frames and modes, including 5-7.
    for (int f = 0; f < 6; f++) begin
      int w, h, m1, m2, chg;
      w = $urandom_range(8, 24);
      h = $urandom_range(6, 12);
      m1 = $urandom_range(0, 7);
      m2 = $urandom_range(0, 7);
      chg = ($urandom_range(0, 1) == 1) ? $urandom_range(1, h - 1) : -1;
      thresh = 4'($urandom_range(0, 15));
      fill_rand(w, h, $urandom_range(20, 85));
      drive_frame(w, h, m1, m2, chg, -1, -1, $urandom_range(0, 4));
    end

    // Threshold frame: 888 is object, 777 is background.
    thresh = 4'd8;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 12; x++)
        rgb[y][x] = ($urandom_range(0, 1) == 1) ? 12'h888 : 12'h777;
    drive_frame(12, 6, 0, 0, -1, -1, -1, 2);

    for (int i = 0; i < 20 && (exp3_q.size() != 0 || exp5_q.size() != 0); i++) idle();
    check("drain_k3", exp3_q.size(), 0);
    check("drain_k5", exp5_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
